// File: rtl/pifo_deq_ctrl.sv
// -----------------------------------------------------------------------------
// pifo_deq_ctrl
//
// Dequeue controller that sits directly downstream of pifo_reg. It watches the
// PIFO's current minimum, issues single-cycle remove strobes, and pushes each
// popped (rank, meta) pair into a small output FIFO. The FIFO feeds the egress
// through a valid/ready handshake.
//
// After any remove or insert, pifo_reg needs a few cycles to recompute its
// min/max. A hold-off counter keeps this block from popping inside that window,
// so a stale minimum is never consumed.
//
// Handshake (egress side): a transfer happens on every rising clk edge where
// deq_valid & deq_ready are both high. While deq_valid is high and deq_ready
// is low, deq_rank/deq_meta stay stable. deq_valid never drops without a
// transfer, except on reset. When deq_valid is low, deq_rank/deq_meta keep
// their last value and carry no meaning.
//
// Ports
//   clk          in   1           clock
//   rst          in   1           synchronous, active-high reset
//   deq_en       in   1           1 = popping permitted, 0 = pause (buffer drains)
//   pifo_rank    in   RANK_WIDTH  pifo_reg rank_out (current minimum)
//   pifo_meta    in   META_WIDTH  pifo_reg meta_out
//   pifo_valid   in   1           pifo_reg valid_out
//   pifo_insert  in   1           copy of the insert strobe into pifo_reg
//   pifo_remove  out  1           remove strobe to pifo_reg, one cycle per pop
//   deq_rank     out  RANK_WIDTH  FIFO head rank
//   deq_meta     out  META_WIDTH  FIFO head meta
//   deq_valid    out  1           FIFO non-empty
//   deq_ready    in   1           egress accepts the head this cycle
//   deq_count    out  32          total pops since reset (wraps)
//   dbg_state    out  1           FSM state (0 = S_IDLE, 1 = S_HOLD)
// -----------------------------------------------------------------------------
module pifo_deq_ctrl #(
    parameter int RANK_WIDTH     = 8,
    parameter int META_WIDTH     = 8,
    parameter int L2_BUF_DEPTH   = 1,
    parameter int HOLDOFF_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  deq_en,
    input  logic [RANK_WIDTH-1:0] pifo_rank,
    input  logic [META_WIDTH-1:0] pifo_meta,
    input  logic                  pifo_valid,
    input  logic                  pifo_insert,
    output logic                  pifo_remove,
    output logic [RANK_WIDTH-1:0] deq_rank,
    output logic [META_WIDTH-1:0] deq_meta,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [31:0]           deq_count,
    output logic                  dbg_state
);

    localparam int BUF_DEPTH = 1 << L2_BUF_DEPTH;
    localparam int PTR_W     = L2_BUF_DEPTH;
    localparam int FCNT_W    = L2_BUF_DEPTH + 1;
    localparam int ENT_W     = RANK_WIDTH + META_WIDTH;
    localparam int CNT_W     = $clog2(HOLDOFF_CYCLES);

    localparam logic [CNT_W-1:0]  HOLD_RELOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [FCNT_W-1:0] BUF_FULL    = FCNT_W'(BUF_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic [ENT_W-1:0]    mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [ENT_W-1:0]    head_q, head_d;
    logic [31:0]         deq_count_q, deq_count_d;

    logic                pop_ok;
    logic                buf_has_room;
    logic                wr_en;
    logic                rd_en;
    logic [ENT_W-1:0]    wr_data;

    // Room is judged on the pre-read fill level, so a full buffer that is
    // being drained this same cycle still refuses the pop.
    assign buf_has_room = (fcnt_q < BUF_FULL);
    assign wr_data      = {pifo_rank, pifo_meta};

    // ------------------------------------------------------------------
    // FSM: next state and pop decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;

        // The strobe depends only on registered state and control inputs.
        // The rank/meta data never reaches it. rst masks it because a pop
        // issued during reset would be discarded here but lost from the PIFO.
        pop_ok = (state_q == S_IDLE) & deq_en & pifo_valid & ~pifo_insert &
                 buf_has_room & ~rst;

        if (pifo_insert || pop_ok) begin
            // Both events start a fresh recompute window inside pifo_reg.
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_RELOAD;
        end else if (state_q == S_HOLD) begin
            if (hold_cnt_q == '0) begin
                state_d = S_IDLE;
            end else begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end
    end

    assign pifo_remove = pop_ok;

    // ------------------------------------------------------------------
    // Output FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_en       = pop_ok;
        rd_en       = (fcnt_q != '0) & deq_ready;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fcnt_d      = fcnt_q;
        head_d      = head_q;
        deq_count_d = deq_count_q;

        if (wr_en) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            deq_count_d = deq_count_q + 32'd1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        // The head register holds the entry that rd_ptr will point at after
        // this edge. If that slot is the one being written now, the data
        // comes straight from the inputs, because mem_q is not updated yet.
        // When the buffer goes empty, the head keeps its old value.
        if (fcnt_d != '0) begin
            if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            head_q      <= '0;
            deq_count_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            head_q      <= head_d;
            deq_count_q <= deq_count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign deq_valid = (fcnt_q != '0);
    assign deq_rank  = head_q[ENT_W-1:META_WIDTH];
    assign deq_meta  = head_q[META_WIDTH-1:0];
    assign deq_count = deq_count_q;
    assign dbg_state = state_q;

endmodule
